// File: rtl/univ_shift_reg_p.sv
// Parametrised universal shift register: parallel load, single shifts (plain/arith/rotate)
// and a counted autonomous burst of back-to-back shifts with a one-cycle done pulse.
module univ_shift_reg_p #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load,
    input  logic             shift_right,
    input  logic             shift_left,
    input  logic             rotate,
    input  logic             arith,
    input  logic             serial_in,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           state_r;
    logic [WIDTH-1:0] out_r;
    logic             serial_out_r;
    logic             busy_r;
    logic             done_r;
    logic             dir_right_r;
    logic             rot_r;
    logic             arith_r;
    logic [CW-1:0]    remaining_r;
    logic             one_dir_s;

    // Returns {bit shifted out, new register value} for a single shift step.
    function automatic logic [WIDTH:0] shift_once(
        input logic [WIDTH-1:0] v,
        input logic             right,
        input logic             rot,
        input logic             ar,
        input logic             sin
    );
        logic fill;
        if (right) begin
            if (rot) begin
                fill = v[0];
            end else if (ar) begin
                fill = v[WIDTH-1];
            end else begin
                fill = sin;
            end
            return {v[0], fill, v[WIDTH-1:1]};
        end else begin
            if (rot) begin
                fill = v[WIDTH-1];
            end else begin
                fill = sin;
            end
            return {v[WIDTH-1], v[WIDTH-2:0], fill};
        end
    endfunction

    assign one_dir_s = shift_right ^ shift_left;

    // Control FSM and datapath; all outputs come straight from registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            out_r        <= {WIDTH{1'b0}};
            serial_out_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            dir_right_r  <= 1'b0;
            rot_r        <= 1'b0;
            arith_r      <= 1'b0;
            remaining_r  <= {CW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        out_r <= pdata;
                    end else if (start && one_dir_s) begin
                        if (count == {CW{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            dir_right_r <= shift_right;
                            rot_r       <= rotate;
                            arith_r     <= arith;
                            remaining_r <= count;
                            busy_r      <= 1'b1;
                            state_r     <= BURST;
                        end
                    end else if (one_dir_s) begin
                        {serial_out_r, out_r} <= shift_once(out_r, shift_right, rotate, arith, serial_in);
                    end else begin
                        out_r <= out_r;
                    end
                end
                BURST: begin
                    {serial_out_r, out_r} <= shift_once(out_r, dir_right_r, rot_r, arith_r, serial_in);
                    remaining_r <= remaining_r - {{(CW-1){1'b0}}, 1'b1};
                    // Last shift of the burst: hand back control and flag completion.
                    if (remaining_r == {{(CW-1){1'b0}}, 1'b1}) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= BURST;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out        = out_r;
    assign serial_out = serial_out_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Self-checking bench for univ_shift_reg_p: directed plan steps followed by random
// stimulus, all compared against an arithmetic reference model.
module tb_univ_shift_reg_p;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int MOD = 2 ** W;
    localparam int HALF = 2 ** (W - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  pdata;
    logic          load, shift_right, shift_left, rotate, arith, serial_in, start;
    logic [CW-1:0] count;
    logic [W-1:0]  out;
    logic          serial_out, busy, done;

    int checks = 0;
    int failures = 0;

    // Reference model state (integers, burst tracked as shifts still owed)
    int m_out = 0, m_sout = 0, m_busy = 0, m_done = 0;
    int m_dir_right = 0, m_rot = 0, m_ar = 0, m_left = 0;

    univ_shift_reg_p #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .pdata(pdata), .load(load),
        .shift_right(shift_right), .shift_left(shift_left), .rotate(rotate),
        .arith(arith), .serial_in(serial_in), .start(start), .count(count),
        .out(out), .serial_out(serial_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_shift(input int right, input int rot, input int ar);
        int fill;
        if (right != 0) begin
            fill = (rot != 0) ? (m_out % 2) : ((ar != 0) ? (m_out / HALF) : int'(serial_in));
            m_sout = m_out % 2;
            m_out  = m_out / 2 + fill * HALF;
        end else begin
            fill = (rot != 0) ? (m_out / HALF) : int'(serial_in);
            m_sout = m_out / HALF;
            m_out  = (m_out * 2) % MOD + fill;
        end
    endtask

    task automatic model_step();
        int nd;
        int one_dir;
        one_dir = (shift_right != shift_left) ? 1 : 0;
        nd = 0;
        if (!rst) begin
            m_out = 0; m_sout = 0; m_left = 0;
        end else if (m_left > 0) begin
            model_shift(m_dir_right, m_rot, m_ar);
            m_left--;
            if (m_left == 0) nd = 1;
        end else if (load) begin
            m_out = int'(pdata);
        end else if (start && one_dir == 1) begin
            if (count == 4'd0) begin
                nd = 1;
            end else begin
                m_dir_right = int'(shift_right);
                m_rot = int'(rotate);
                m_ar = int'(arith);
                m_left = int'(count);
            end
        end else if (one_dir == 1) begin
            model_shift(int'(shift_right), int'(rotate), int'(arith));
        end
        m_done = nd;
        m_busy = (m_left > 0) ? 1 : 0;
    endtask

    // One clock: advance model with the current inputs, then compare all outputs after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("out", int'(out), m_out);
        chk("serial_out", int'(serial_out), m_sout);
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), m_done);
    endtask

    task automatic idle_inputs();
        rst = 1'b1; pdata = 8'h00; load = 1'b0; shift_right = 1'b0; shift_left = 1'b0;
        rotate = 1'b0; arith = 1'b0; serial_in = 1'b0; start = 1'b0; count = 4'd0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        idle_inputs(); load = 1'b1; pdata = v; tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        // Reset
        rst = 1'b0; tick(); tick();
        chk("rst_out", int'(out), 0);
        chk("rst_busy", int'(busy), 0);

        // 1: plain right shifts
        do_load(8'h13);
        shift_right = 1'b1; serial_in = 1'b0; tick();
        chk("p1_out_a", int'(out), 8'h09); chk("p1_sout_a", int'(serial_out), 1);
        tick();
        chk("p1_out_b", int'(out), 8'h04); chk("p1_sout_b", int'(serial_out), 1);

        // 2: left shift with serial_in=1, then both directions hold
        do_load(8'h13);
        shift_left = 1'b1; serial_in = 1'b1; tick();
        chk("p2_out", int'(out), 8'h27); chk("p2_sout", int'(serial_out), 0);
        shift_right = 1'b1; tick();
        chk("p2_hold", int'(out), 8'h27);

        // 3: arithmetic right and rotate right
        do_load(8'h93);
        shift_right = 1'b1; arith = 1'b1; tick();
        chk("p3_arith", int'(out), 8'hC9);
        do_load(8'h13);
        shift_right = 1'b1; rotate = 1'b1; tick();
        chk("p3_rot", int'(out), 8'h89); chk("p3_rot_sout", int'(serial_out), 1);

        // 4: rotate-left burst of 3, load attempt mid-burst
        do_load(8'h13);
        start = 1'b1; count = 4'd3; shift_left = 1'b1; rotate = 1'b1; tick();
        chk("p4_busy0", int'(busy), 1); chk("p4_noshift", int'(out), 8'h13);
        idle_inputs(); tick();
        chk("p4_s1", int'(out), 8'h26);
        load = 1'b1; pdata = 8'hFF; tick();
        chk("p4_s2", int'(out), 8'h4C);
        tick();
        chk("p4_s3", int'(out), 8'h98); chk("p4_done", int'(done), 1); chk("p4_idle", int'(busy), 0);
        idle_inputs(); tick();
        chk("p4_done_low", int'(done), 0);

        // 5: zero-length burst, then start without direction
        start = 1'b1; count = 4'd0; shift_right = 1'b1; tick();
        chk("p5_done", int'(done), 1); chk("p5_busy", int'(busy), 0); chk("p5_out", int'(out), 8'h98);
        idle_inputs(); tick();
        chk("p5_done_low", int'(done), 0);
        start = 1'b1; count = 4'd4; tick(); tick();
        chk("p5_nodir_busy", int'(busy), 0); chk("p5_nodir_out", int'(out), 8'h98);

        // 6: reset in the middle of a 5-shift burst
        idle_inputs(); start = 1'b1; count = 4'd5; shift_right = 1'b1; serial_in = 1'b1; tick();
        start = 1'b0; shift_right = 1'b0; tick(); tick();
        rst = 1'b0; tick();
        chk("p6_out", int'(out), 0); chk("p6_busy", int'(busy), 0); chk("p6_sout", int'(serial_out), 0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("p6_no_done", int'(done), 0);
        end

        // Random phase
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) != 0);
            pdata       = W'($urandom);
            load        = ($urandom_range(0, 7) == 0);
            shift_right = $urandom_range(0, 1) == 1;
            shift_left  = $urandom_range(0, 1) == 1;
            rotate      = $urandom_range(0, 2) == 0;
            arith       = $urandom_range(0, 1) == 1;
            serial_in   = $urandom_range(0, 1) == 1;
            start       = ($urandom_range(0, 4) == 0);
            count       = CW'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
